// File: rtl/uart_rx_deserializer_ext_if.sv
// uart_rx_deserializer_ext_if: sampler/FSM-side inputs and word-side outputs of the RX deserializer
interface uart_rx_deserializer_ext_if #(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_W = 6
);
    logic                  sampled_bit;
    logic                  deslz_en;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [EDGE_W-1:0]     sample_edge;
    logic                  clr;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_out;
    logic [3:0]            bit_cnt;
    modport master (
        output sampled_bit, deslz_en, edge_cnt, sample_edge, clr,
        input  p_data, data_valid, par_out, bit_cnt
    );
    modport slave (
        input  sampled_bit, deslz_en, edge_cnt, sample_edge, clr,
        output p_data, data_valid, par_out, bit_cnt
    );
endinterface

// File: rtl/uart_rx_deserializer_ext.sv
// uart_rx_deserializer_ext: edge-armed bit capture into a stable parallel word with XOR parity
module uart_rx_deserializer_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_W = 6,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic clk,
    input logic rest,
    uart_rx_deserializer_ext_if.slave bus
);
    logic                  match;
    logic                  match_d;
    logic                  cap;
    logic                  last;
    logic                  par_acc;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] word;
    // capture fires only on the first cycle of a match window; word includes the incoming bit
    always_comb begin
        match = bus.deslz_en && (bus.edge_cnt == bus.sample_edge);
        cap = match && !match_d;
        last = bus.bit_cnt == 4'(DATA_WIDTH - 1);
        word = MSB_FIRST ? {sh[DATA_WIDTH-2:0], bus.sampled_bit} : {bus.sampled_bit, sh[DATA_WIDTH-1:1]};
    end
    // shift/parity accumulation; p_data and par_out move only when a word completes
    always_ff @(posedge clk) begin
        if (rest) begin
            sh <= '0;
            par_acc <= 1'b0;
            match_d <= 1'b0;
            bus.bit_cnt <= '0;
            bus.p_data <= '0;
            bus.par_out <= 1'b0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            if (bus.clr) begin
                sh <= '0;
                par_acc <= 1'b0;
                match_d <= 1'b0;
                bus.bit_cnt <= '0;
            end else begin
                match_d <= match;
                if (cap) begin
                    sh <= word;
                    if (last) begin
                        par_acc <= 1'b0;
                        bus.bit_cnt <= '0;
                        bus.p_data <= word;
                        bus.par_out <= par_acc ^ bus.sampled_bit;
                        bus.data_valid <= 1'b1;
                    end else begin
                        par_acc <= par_acc ^ bus.sampled_bit;
                        bus.bit_cnt <= bus.bit_cnt + 4'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer_ext.sv
// tb_uart_rx_deserializer_ext: directed checks on LSB/MSB-first 8-bit and LSB-first 5-bit instances
module tb_uart_rx_deserializer_ext;
    logic       clk = 1'b0;
    logic       rest = 1'b1;
    logic       sb = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] ec = '0;
    logic [2:0] en = '0;
    int         sel = 0;
    int         n_checks = 0;
    int         n_err = 0;
    logic [8:0] obs_p;
    logic       obs_v;
    logic       obs_par;
    logic [3:0] obs_cnt;

    uart_rx_deserializer_ext_if #(.DATA_WIDTH(8), .EDGE_W(6)) i8l ();
    uart_rx_deserializer_ext_if #(.DATA_WIDTH(8), .EDGE_W(6)) i8m ();
    uart_rx_deserializer_ext_if #(.DATA_WIDTH(5), .EDGE_W(6)) i5 ();

    assign i8l.sampled_bit = sb;
    assign i8l.edge_cnt = ec;
    assign i8l.sample_edge = 6'd7;
    assign i8l.clr = clr;
    assign i8l.deslz_en = en[0];
    assign i8m.sampled_bit = sb;
    assign i8m.edge_cnt = ec;
    assign i8m.sample_edge = 6'd7;
    assign i8m.clr = clr;
    assign i8m.deslz_en = en[1];
    assign i5.sampled_bit = sb;
    assign i5.edge_cnt = ec;
    assign i5.sample_edge = 6'd7;
    assign i5.clr = clr;
    assign i5.deslz_en = en[2];

    uart_rx_deserializer_ext #(.DATA_WIDTH(8), .EDGE_W(6), .MSB_FIRST(1'b0)) u8l (.clk(clk), .rest(rest), .bus(i8l.slave));
    uart_rx_deserializer_ext #(.DATA_WIDTH(8), .EDGE_W(6), .MSB_FIRST(1'b1)) u8m (.clk(clk), .rest(rest), .bus(i8m.slave));
    uart_rx_deserializer_ext #(.DATA_WIDTH(5), .EDGE_W(6), .MSB_FIRST(1'b0)) u5 (.clk(clk), .rest(rest), .bus(i5.slave));

    always #5 clk = ~clk;

    // observe whichever instance the current step targets
    always_comb begin
        obs_p = sel == 0 ? {1'b0, i8l.p_data} : sel == 1 ? {1'b0, i8m.p_data} : {4'b0, i5.p_data};
        obs_v = sel == 0 ? i8l.data_valid : sel == 1 ? i8m.data_valid : i5.data_valid;
        obs_par = sel == 0 ? i8l.par_out : sel == 1 ? i8m.par_out : i5.par_out;
        obs_cnt = sel == 0 ? i8l.bit_cnt : sel == 1 ? i8m.bit_cnt : i5.bit_cnt;
    end

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s (dut %0d): got %0h expected %0h", tag, sel, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_bit(input logic b);
        sb = b;
        ec = 6'd7;
        tick();
        ec = 6'd0;
        tick();
    endtask

    task automatic frame(input int n, input logic [8:0] v, input bit msb, input logic [8:0] prev_p, input logic exp_par);
        for (int i = 0; i < n; i++) begin
            sb = msb ? v[n-1-i] : v[i];
            ec = 6'd7;
            tick();
            if (i < n - 1) begin
                chk("bit_cnt", {5'b0, obs_cnt}, 9'(i + 1));
                chk("p_data_hold", obs_p, prev_p);
                chk("dv_low", {8'b0, obs_v}, 9'd0);
            end else begin
                chk("bit_cnt_wrap", {5'b0, obs_cnt}, 9'd0);
                chk("p_data", obs_p, v);
                chk("par_out", {8'b0, obs_par}, {8'b0, exp_par});
                chk("dv_high", {8'b0, obs_v}, 9'd1);
            end
            ec = 6'd0;
            tick();
        end
        chk("dv_one_cycle", {8'b0, obs_v}, 9'd0);
        chk("p_data_stable", obs_p, v);
    endtask

    initial begin
        tick();
        tick();
        rest = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_p_data", obs_p, 9'd0);
            chk("rst_par", {8'b0, obs_par}, 9'd0);
            chk("rst_dv", {8'b0, obs_v}, 9'd0);
            chk("rst_cnt", {5'b0, obs_cnt}, 9'd0);
        end
        sel = 0;
        en = 3'b001;
        frame(8, 9'h0A5, 1'b0, 9'h000, 1'b0);
        sel = 1;
        en = 3'b010;
        #1;
        frame(8, 9'h0D0, 1'b1, 9'h000, 1'b1);
        sel = 0;
        en = 3'b001;
        #1;
        sb = 1'b1;
        ec = 6'd7;
        repeat (4) tick();
        chk("long_match_cnt", {5'b0, obs_cnt}, 9'd1);
        ec = 6'd0;
        tick();
        chk("long_match_after", {5'b0, obs_cnt}, 9'd1);
        pulse_bit(1'b0);
        pulse_bit(1'b0);
        chk("pre_clr_cnt", {5'b0, obs_cnt}, 9'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", {5'b0, obs_cnt}, 9'd0);
        chk("clr_p_hold", obs_p, 9'h0A5);
        chk("clr_dv", {8'b0, obs_v}, 9'd0);
        clr = 1'b1;
        ec = 6'd7;
        tick();
        clr = 1'b0;
        ec = 6'd0;
        chk("clr_discards_cap", {5'b0, obs_cnt}, 9'd0);
        tick();
        frame(8, 9'h03C, 1'b0, 9'h0A5, 1'b0);
        for (int i = 0; i < 5; i++) pulse_bit(1'b1);
        chk("pre_rest_cnt", {5'b0, obs_cnt}, 9'd5);
        rest = 1'b1;
        tick();
        rest = 1'b0;
        chk("rest_p_data", obs_p, 9'd0);
        chk("rest_par", {8'b0, obs_par}, 9'd0);
        chk("rest_dv", {8'b0, obs_v}, 9'd0);
        chk("rest_cnt", {5'b0, obs_cnt}, 9'd0);
        frame(8, 9'h0FF, 1'b0, 9'h000, 1'b0);
        en = 3'b000;
        sb = 1'b1;
        ec = 6'd7;
        tick();
        tick();
        ec = 6'd0;
        chk("en_low_no_cap", {5'b0, obs_cnt}, 9'd0);
        tick();
        sel = 2;
        en = 3'b100;
        #1;
        frame(5, 9'h015, 1'b0, 9'h000, 1'b1);
        frame(5, 9'h00A, 1'b0, 9'h015, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer_ext.md
# uart_rx_deserializer_ext

Parametrised UART receive deserializer that sits between the RX data sampler and the frame checker in the UART RX path. It shifts one sampled bit per bit period into a DATA_WIDTH-wide word and selects LSB-first or MSB-first order. It tracks the bit position internally and presents a stable parallel word, a one-cycle valid strobe and the word's XOR parity. Unlike the previous generation, the output word does not move while bits are arriving, and one sample window cannot produce two captures.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- EDGE_W, 6: width of the edge counter and sample-edge compare value.
- MSB_FIRST, 0: 0 = first received bit lands in p_data[0]; 1 = first received bit lands in p_data[DATA_WIDTH-1].
- clk  in  1  single clock domain; all state updates on the rising edge.
- rest  in  1  reset, synchronous, active-high; highest priority.
- sampled_bit  in  1  majority-voted bit from the sampler.
- deslz_en  in  1  deserializer enable from the RX FSM; high during data bits only.
- edge_cnt  in  EDGE_W  oversampling edge counter within the current bit.
- sample_edge  in  EDGE_W  edge_cnt value at which sampled_bit is valid, typically prescale-1. Quasi-static.
- clr  in  1  start-of-frame clear from the RX FSM (start bit accepted).
- p_data  out  DATA_WIDTH  last completed word (registered).
- data_valid  out  1  one-cycle pulse: p_data/par_out just updated.
- par_out  out  1  XOR of all DATA_WIDTH bits of p_data (registered).
- bit_cnt  out  4  number of bits captured in the current, incomplete word (0..DATA_WIDTH-1).

## Operation
- Capture condition: match = deslz_en && (edge_cnt == sample_edge). A capture fires on a cycle where match=1 and match was 0 on the previous cycle. A registered match_d flag (reset 0) provides the previous-cycle value. One capture per match window, however long edge_cnt stays at sample_edge.
- Priority per cycle: rest > clr > capture > hold.
- Capture, LSB-first: sh <= {sampled_bit, sh[DATA_WIDTH-1:1]}. After DATA_WIDTH captures, the first bit is at bit 0.
- Capture, MSB-first: sh <= {sh[DATA_WIDTH-2:0], sampled_bit}.
- Each capture sets par_acc <= par_acc ^ sampled_bit and increments bit_cnt.
- Final capture (bit_cnt == DATA_WIDTH-1 on the capture cycle):
  - p_data <= assembled word, including this bit;
  - par_out <= par_acc ^ sampled_bit;
  - data_valid <= 1;
  - bit_cnt, par_acc <= 0; sh may hold any value.
- Any captures after a completed word start a new word; no idle state is needed.
- clr: sh, bit_cnt, par_acc <= 0 and match_d <= 0. p_data and par_out hold. data_valid <= 0. clr together with a capture discards the capture.
- deslz_en low: no capture; partial-word state holds; match_d <= 0.
- p_data and par_out change only on the final-capture cycle or on rest.

## Timing
- Reset values (rest=1 at a clk edge): p_data=0, par_out=0, data_valid=0, bit_cnt=0, sh=0, par_acc=0, match_d=0.
- Reset applies mid-frame: partial word discarded, no data_valid.
- Latency: p_data, par_out and data_valid are visible in the same cycle bit_cnt returns to 0, i.e. one clk after the edge at which the final match is first seen.
- data_valid is high for exactly one clk per completed word and is deasserted on the following cycle unconditionally.
- bit_cnt updates one clk after each capture-qualifying cycle.
- Minimum spacing between captures: 2 clk, because match must drop for one cycle to re-arm.
- sample_edge changes while deslz_en=1 are unsupported. The only requirement is no more than one capture per rising edge of match.

## Test plan
- DATA_WIDTH=8, MSB_FIRST=0, sample_edge=7. Send LSB-first bits of 0xA5: 1,0,1,0,0,1,0,1.
  - p_data=0xA5, par_out=0, data_valid high for 1 cycle.
  - bit_cnt sequence 1..7 then 0.
  - p_data=0 throughout the frame before completion.
- MSB_FIRST=1: send bits 1,1,0,1,0,0,0,0 -> p_data=0xD0, par_out=1.
- edge_cnt held equal to sample_edge for 4 cycles with deslz_en=1 -> exactly one capture, bit_cnt increments by 1.
- After 3 bits, assert clr for 1 cycle, then send a full 0x3C.
  - p_data=0x3C, par_out=0, single data_valid.
  - Previous p_data held until completion.
- After 5 bits, assert rest for 1 cycle -> all outputs 0 next cycle. A following full frame of 0xFF yields p_data=0xFF, par_out=0.
- DATA_WIDTH=5: two back-to-back frames 0x15 then 0x0A -> two data_valid pulses, p_data=0x15 then 0x0A, par_out=1 then 0.
